// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier datapath.
// Strobe priority encoding lives here so control and datapath agree.
package mult_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLRLD,
        OP_SUB,
        OP_ADD,
        OP_SHIFT
    } op_t;

    function automatic op_t prio_op(
        input logic clr_ld,
        input logic sub,
        input logic add,
        input logic shift
    );
        op_t op;
        op = OP_NONE;
        if (clr_ld)
            op = OP_CLRLD;
        else if (sub)
            op = OP_SUB;
        else if (add)
            op = OP_ADD;
        else if (shift)
            op = OP_SHIFT;
        return op;
    endfunction

endpackage

// File: rtl/addsub9.sv
// Combinational signed adder/subtractor, one bit wider than the operands
// so the true sign of the result always survives.
module addsub9 #(
    parameter int W = mult_pkg::WIDTH
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] MC,
    input  logic         sub,
    output logic [W:0]   sum9
);

    logic [W:0] w_a;
    logic [W:0] w_b;

    assign w_a  = {A[W-1], A};
    assign w_b  = {MC[W-1], MC} ^ {(W+1){sub}};
    assign sum9 = w_a + w_b + {{W{1'b0}}, sub};

endmodule

// File: rtl/mult_datapath.sv
// {X,A,B} product register and adder for the signed shift-add multiplier.
// Optional MULT_DP_SNAPSHOT_EN latches the multiplicand on Clr_Ld.
module mult_datapath #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clr_Ld,
    input  logic             Shift,
    input  logic             Add,
    input  logic             Sub,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             M
);

    import mult_pkg::*;

    logic             r_x;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_mc;
    logic [WIDTH:0]   w_sum;
    logic             w_sub;
    op_t              w_op;

    assign w_op  = prio_op(Clr_Ld, Sub, Add, Shift);
    assign w_sub = (w_op == OP_SUB);

`ifdef MULT_DP_SNAPSHOT_EN
    logic [WIDTH-1:0] r_s;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_s <= '0;
        else if (Clr_Ld)
            r_s <= Din;
    end

    assign w_mc = r_s;
`else
    assign w_mc = Din;
`endif

    addsub9 #(.W(WIDTH)) u_addsub (
        .A    (r_a),
        .MC   (w_mc),
        .sub  (w_sub),
        .sum9 (w_sum)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x <= 1'b0;
            r_a <= '0;
            r_b <= '0;
        end else begin
            unique case (w_op)
                OP_CLRLD: begin
                    r_x <= 1'b0;
                    r_a <= '0;
                    if (ClearA_LoadB)
                        r_b <= Din;
                end
                OP_SUB, OP_ADD: begin
                    r_x <= w_sum[WIDTH];
                    r_a <= w_sum[WIDTH-1:0];
                end
                // X is replicated, so the 17-bit value shifts arithmetically
                OP_SHIFT: begin
                    r_a <= {r_x, r_a[WIDTH-1:1]};
                    r_b <= {r_a[0], r_b[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign Aval = r_a;
    assign Bval = r_b;
    assign X    = r_x;
    assign M    = r_b[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed steps plus random
// operations and multiplies against an arithmetic reference model.
module tb_mult_datapath;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Clr_Ld;
    logic       Shift;
    logic       Add;
    logic       Sub;
    logic       ClearA_LoadB;
    logic [7:0] Din;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       M;

    int tests = 0;
    int fails = 0;

    logic       mx;
    logic [7:0] ma;
    logic [7:0] mb;
    logic [7:0] ms;

    always #5 Clk = ~Clk;

    mult_datapath dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Clr_Ld       (Clr_Ld),
        .Shift        (Shift),
        .Add          (Add),
        .Sub          (Sub),
        .ClearA_LoadB (ClearA_LoadB),
        .Din          (Din),
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .M            (M)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".A"}, {24'd0, Aval}, {24'd0, ma});
        chk({tag, ".B"}, {24'd0, Bval}, {24'd0, mb});
        chk({tag, ".X"}, {31'd0, X}, {31'd0, mx});
        chk({tag, ".M"}, {31'd0, M}, {31'd0, mb[0]});
    endtask

    // drive one cycle of strobes and advance the reference model
    task automatic apply(input logic c, input logic l, input logic s,
                         input logic a, input logic sh,
                         input logic [7:0] d);
        logic [7:0] mc;
        int r;
        Clr_Ld = c;
        ClearA_LoadB = l;
        Sub = s;
        Add = a;
        Shift = sh;
        Din = d;
        mc = d;
`ifdef MULT_DP_SNAPSHOT_EN
        mc = ms;
`endif
        if (c) begin
            mx = 1'b0;
            ma = 8'h00;
            if (l)
                mb = d;
        end else if (s) begin
            r = $signed(ma) - $signed(mc);
            mx = (r < 0);
            ma = r[7:0];
        end else if (a) begin
            r = $signed(ma) + $signed(mc);
            mx = (r < 0);
            ma = r[7:0];
        end else if (sh) begin
            mb = {ma[0], mb[7:1]};
            ma = {mx, ma[7:1]};
        end
        if (c)
            ms = d;
        @(posedge Clk);
        #1;
        Clr_Ld = 1'b0;
        Sub = 1'b0;
        Add = 1'b0;
        Shift = 1'b0;
    endtask

    task automatic mul(input string tag, input logic [7:0] b,
                       input logic [7:0] mc);
        logic [7:0] d;
        int p;
        apply(1, 1, 0, 0, 0, b);
        apply(1, 0, 0, 0, 0, mc);
        for (int i = 0; i < 8; i++) begin
            d = mc;
`ifdef MULT_DP_SNAPSHOT_EN
            d = 8'($urandom);
`endif
            chk({tag, ".M"}, {31'd0, M}, {31'd0, b[i]});
            if (b[i])
                apply(0, 0, i == 7, i != 7, 0, d);
            apply(0, 0, 0, 0, 1, d);
        end
        p = $signed(b) * $signed(mc);
        chk({tag, ".P"}, {16'd0, Aval, Bval}, {16'd0, p[15:0]});
        chk({tag, ".X"}, {31'd0, X}, {31'd0, p < 0});
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] rm;
        logic [3:0] st;

        Reset_n = 1'b0;
        Clr_Ld = 1'b0;
        Shift = 1'b0;
        Add = 1'b0;
        Sub = 1'b0;
        ClearA_LoadB = 1'b0;
        Din = 8'h00;
        mx = 1'b0;
        ma = 8'h00;
        mb = 8'h00;
        ms = 8'h00;
        #3;
        chk_model("rst0");
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;

        apply(1, 1, 0, 0, 0, 8'h07);
        chk("ld.B", {24'd0, Bval}, 32'h07);
        chk("ld.A", {24'd0, Aval}, 32'h00);
        chk("ld.X", {31'd0, X}, 32'd0);
        chk("ld.M", {31'd0, M}, 32'd1);
        apply(1, 0, 0, 0, 0, 8'h33);
        chk("clr.B", {24'd0, Bval}, 32'h07);

        apply(0, 0, 0, 1, 0, 8'hC5);
        chk("add.X", {31'd0, X}, 32'd1);
        chk("add.A", {24'd0, Aval}, 32'hC5);
        apply(0, 0, 0, 0, 1, 8'hC5);
        chk("sh.X", {31'd0, X}, 32'd1);
        chk("sh.A", {24'd0, Aval}, 32'hE2);
        chk("sh.B", {24'd0, Bval}, 32'h83);

        apply(1, 0, 0, 0, 0, 8'h7F);
        apply(0, 0, 0, 1, 0, 8'h7F);
        apply(0, 0, 0, 1, 0, 8'h01);
        chk("ovf.X", {31'd0, X}, 32'd0);
        chk("ovf.A", {24'd0, Aval}, 32'h80);
        apply(1, 0, 0, 0, 0, 8'h80);
        apply(0, 0, 1, 0, 0, 8'h80);
        chk("subovf.X", {31'd0, X}, 32'd0);
        chk("subovf.A", {24'd0, Aval}, 32'h80);

        apply(1, 0, 0, 0, 0, 8'h10);
        apply(0, 0, 0, 1, 1, 8'h10);
        chk("prio.A", {24'd0, Aval}, 32'h10);
        chk("prio.B", {24'd0, Bval}, {24'd0, mb});

        mul("mul7", 8'h07, 8'hC5);
        chk("mul7.AB", {16'd0, Aval, Bval}, 32'hFE63);
        chk("mul7.Xc", {31'd0, X}, 32'd1);
        mul("mul80", 8'h80, 8'h80);
        chk("mul80.AB", {16'd0, Aval, Bval}, 32'h4000);
        chk("mul80.Xc", {31'd0, X}, 32'd0);

        apply(1, 1, 0, 0, 0, 8'hAA);
        apply(0, 0, 0, 1, 0, 8'hAB);
        apply(0, 0, 0, 1, 0, 8'hAA);
        chk_model("pre_rst");
        chk("pre_rst.Ac", {24'd0, Aval}, 32'h55);
        #2;
        Reset_n = 1'b0;
        #1;
        mx = 1'b0;
        ma = 8'h00;
        mb = 8'h00;
        ms = 8'h00;
        chk_model("arst");
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            st = 4'($urandom);
            rm = 8'($urandom);
            if (n % 5 == 0)
                apply(1, st[0], 0, 0, 0, rm);
            else
                apply(st[3] & st[2] & st[1], st[0],
                      st[2], st[1], st[0] | st[3], rm);
            chk_model("rnd");
        end

        for (int n = 0; n < 20; n++) begin
            rb = 8'($urandom);
            rm = 8'($urandom);
            mul("rmul", rb, rm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
